// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and byte-lane helpers for the wait-state data memory
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } memState_t;

    localparam int LANE_W    = 8;
    localparam int NUM_LANES = 4;

    localparam logic [NUM_LANES-1:0] BE_NONE = 4'b0000;

    // Replace only the enabled byte lanes of oldWord with those of newWord.
    function automatic logic [31:0] be_merge(input logic [31:0] oldWord,
                                             input logic [31:0] newWord,
                                             input logic [NUM_LANES-1:0] be);
        logic [31:0] result;
        result = oldWord;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (be[i]) begin
                result[i*LANE_W +: LANE_W] = newWord[i*LANE_W +: LANE_W];
            end
        end
        return result;
    endfunction

    // Force disabled byte lanes of a read word to zero.
    function automatic logic [31:0] be_mask_rd(input logic [31:0] word,
                                               input logic [NUM_LANES-1:0] be);
        logic [31:0] result;
        result = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (be[i]) begin
                result[i*LANE_W +: LANE_W] = word[i*LANE_W +: LANE_W];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// rtl/data_mem_array.sv - DEPTHx32 storage, synchronous byte-masked write, asynchronous read
import mips_mem_pkg::*;

module data_mem_array #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic                 Clk,
    input  logic                 WrEn,
    input  logic [3:0]           WrBe,
    input  logic [ADDR_W-1:0]    WrIdx,
    input  logic [31:0]          WrData,
    input  logic [ADDR_W-1:0]    RdIdx,
    output logic [31:0]          RdData
);

    // Storage is deliberately unreset so it can map onto a RAM macro.
    logic [31:0] memArray [DEPTH];

    // Byte-masked write: lanes with a cleared enable keep their old contents.
    always_ff @(posedge Clk) begin
        if (WrEn) begin
            memArray[WrIdx] <= be_merge(memArray[WrIdx], WrData, WrBe);
        end
    end

    assign RdData = memArray[RdIdx];

endmodule

// File: rtl/data_mem_ws.sv
// rtl/data_mem_ws.sv - word-addressed data memory with wait states, byte masking and range check
import mips_mem_pkg::*;

module data_mem_ws #(
    parameter int DEPTH         = 64,
    parameter int ADDR_W        = 6,
    parameter int LATENCY       = 2,
    parameter int RD_ZERO_LANES = 1
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        CS,
    input  logic        RW,
    input  logic [3:0]  BE,
    input  logic [29:0] Addr,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        DataReady,
    output logic        Busy,
    output logic        AddrErr
);

    localparam logic [3:0] LAT4     = 4'(LATENCY);
    localparam bit         ZERO_LAT = (LATENCY == 0);

    generate
        if (LATENCY < 0 || LATENCY > 15) begin : gen_bad_latency
            $error("data_mem_ws: LATENCY must be within 0..15");
        end
        if (DEPTH < 4 || DEPTH > 1024 || DEPTH != (1 << ADDR_W)) begin : gen_bad_depth
            $error("data_mem_ws: DEPTH must be a power of two 4..1024 equal to 2**ADDR_W");
        end
    endgenerate

    memState_t   state;
    logic [3:0]  waitCnt;
    logic        latRw;
    logic [3:0]  latBe;
    logic [29:0] latAddr;
    logic [31:0] latData;

    logic              accept;
    logic              commit;
    logic              selRw;
    logic [3:0]        selBe;
    logic [29:0]       selAddr;
    logic [31:0]       selData;
    logic              outOfRange;
    logic [ADDR_W-1:0] idx;
    logic              memWe;
    logic [31:0]       rdWord;
    logic [31:0]       rdResult;

    // Commit happens on the edge that enters DONE; with zero latency that is
    // the accept edge itself, so the live bus values are used instead of the latches.
    always_comb begin
        accept     = (state == IDLE) && CS;
        commit     = (accept && ZERO_LAT) || ((state == WAIT) && (waitCnt == 4'd1));
        selRw      = (state == IDLE) ? RW     : latRw;
        selBe      = (state == IDLE) ? BE     : latBe;
        selAddr    = (state == IDLE) ? Addr   : latAddr;
        selData    = (state == IDLE) ? DataIn : latData;
        outOfRange = |selAddr[29:ADDR_W];
        idx        = selAddr[ADDR_W-1:0];
        memWe      = commit && selRw && !outOfRange;
        rdResult   = '0;
        if (!outOfRange) begin
            rdResult = (RD_ZERO_LANES != 0) ? be_mask_rd(rdWord, selBe) : rdWord;
        end
    end

    data_mem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .Clk    (Clk),
        .WrEn   (memWe),
        .WrBe   (selBe),
        .WrIdx  (idx),
        .WrData (selData),
        .RdIdx  (idx),
        .RdData (rdWord)
    );

    // Handshake FSM: accept, count wait states, one-cycle DONE with registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            waitCnt   <= 4'd0;
            latRw     <= 1'b0;
            latBe     <= BE_NONE;
            latAddr   <= '0;
            latData   <= '0;
            DataOut   <= '0;
            DataReady <= 1'b0;
            Busy      <= 1'b0;
            AddrErr   <= 1'b0;
        end else begin
            DataReady <= commit;
            AddrErr   <= commit && outOfRange;
            if (commit && !selRw) begin
                DataOut <= rdResult;
            end
            case (state)
                IDLE: begin
                    if (CS) begin
                        latRw   <= RW;
                        latBe   <= BE;
                        latAddr <= Addr;
                        latData <= DataIn;
                        waitCnt <= LAT4;
                        Busy    <= 1'b1;
                        state   <= ZERO_LAT ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (waitCnt == 4'd1) begin
                        state <= DONE;
                    end else begin
                        waitCnt <= waitCnt - 4'd1;
                    end
                end
                DONE: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
